// File: rtl/if_id_reg.sv
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register with fetch address check, flush bubble,
//            stall hold and a saturating stall-cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        if_bd,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc8,
    output logic [4:0]  id_exccode,
    output logic        id_bd,
    output logic        id_valid,
    output logic [15:0] stall_cnt
);

    localparam logic [31:0] c_reset_pc   = 32'h0000_3000;
    localparam logic [31:0] c_exc_pc     = 32'h0000_4180;
    localparam logic [31:0] c_text_lo    = 32'h0000_3000;
    localparam logic [31:0] c_text_hi    = 32'h0000_6FFC;
    localparam logic [4:0]  c_exc_adel   = 5'd4;
    localparam logic [15:0] c_cnt_max    = 16'hFFFF;

    // Declaration initialisers give the power-on state equal to reset.
    logic [31:0] r_pc       = c_reset_pc;
    logic [31:0] r_pc8      = c_reset_pc + 32'd8;
    logic [31:0] r_instr    = 32'd0;
    logic [4:0]  r_exccode  = 5'd0;
    logic        r_bd       = 1'b0;
    logic        r_valid    = 1'b0;
    logic [15:0] r_stall_cnt = 16'd0;

    logic        w_bad_addr;

    assign w_bad_addr = (if_pc[1:0] != 2'b00) || (if_pc < c_text_lo) || (if_pc > c_text_hi);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc        <= c_reset_pc;
            r_pc8       <= c_reset_pc + 32'd8;
            r_instr     <= 32'd0;
            r_exccode   <= 5'd0;
            r_bd        <= 1'b0;
            r_valid     <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else if (flush) begin
            r_pc        <= c_exc_pc;
            r_pc8       <= c_exc_pc + 32'd8;
            r_instr     <= 32'd0;
            r_exccode   <= 5'd0;
            r_bd        <= 1'b0;
            r_valid     <= 1'b0;
        end else if (stall) begin
            if (r_stall_cnt != c_cnt_max) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end else begin
            r_pc        <= if_pc;
            r_pc8       <= if_pc + 32'd8;
            r_bd        <= if_bd;
            r_valid     <= 1'b1;
            r_instr     <= w_bad_addr ? 32'd0 : if_instr;
            r_exccode   <= w_bad_addr ? c_exc_adel : 5'd0;
        end
    end

    assign id_pc      = r_pc;
    assign id_pc8     = r_pc8;
    assign id_instr   = r_instr;
    assign id_exccode = r_exccode;
    assign id_bd      = r_bd;
    assign id_valid   = r_valid;
    assign stall_cnt  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_if_id_reg.sv
// ============================================================================
// Module   : tb_if_id_reg
// Purpose  : Directed vector table, saturation run and randomized comparison
//            against a behavioural model for if_id_reg.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_id_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_bd;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc8;
    logic [4:0]  id_exccode;
    logic        id_bd;
    logic        id_valid;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    longint m_pc, m_pc8, m_instr, m_exc, m_bd, m_valid, m_cnt;

    typedef struct {
        logic        rst_n;
        logic        fl;
        logic        st;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic [31:0] e_pc;
        logic [31:0] e_pc8;
        logic [31:0] e_instr;
        logic [4:0]  e_exc;
        logic        e_bd;
        logic        e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[19];

    if_id_reg dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_bd      (if_bd),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_pc8     (id_pc8),
        .id_exccode (id_exccode),
        .id_bd      (id_bd),
        .id_valid   (id_valid),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pc8,
                           input logic [31:0] e_instr, input logic [4:0] e_exc,
                           input logic e_bd, input logic e_valid, input logic [15:0] e_cnt);
        chk({tag, ".id_pc"},      id_pc,              e_pc);
        chk({tag, ".id_pc8"},     id_pc8,             e_pc8);
        chk({tag, ".id_instr"},   id_instr,           e_instr);
        chk({tag, ".id_exccode"}, {27'd0, id_exccode}, {27'd0, e_exc});
        chk({tag, ".id_bd"},      {31'd0, id_bd},      {31'd0, e_bd});
        chk({tag, ".id_valid"},   {31'd0, id_valid},   {31'd0, e_valid});
        chk({tag, ".stall_cnt"},  {16'd0, stall_cnt},  {16'd0, e_cnt});
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_pc[31:0], m_pc8[31:0], m_instr[31:0], m_exc[4:0],
                m_bd[0], m_valid[0], m_cnt[15:0]);
    endtask

    // Next state from the rules: reset > flush > stall > load.
    task automatic model_step();
        longint pc;
        bit     bad;
        pc = longint'(if_pc);
        if (reset == 1'b0) begin
            m_pc = 'h3000; m_pc8 = 'h3008; m_instr = 0; m_exc = 0;
            m_bd = 0; m_valid = 0; m_cnt = 0;
        end else if (flush) begin
            m_pc = 'h4180; m_pc8 = 'h4188; m_instr = 0; m_exc = 0;
            m_bd = 0; m_valid = 0;
        end else if (stall) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            bad     = (pc % 4 != 0) || (pc < 'h3000) || (pc > 'h6FFC);
            m_pc    = pc;
            m_pc8   = (pc + 8) % (64'd1 << 32);
            m_bd    = longint'(if_bd);
            m_valid = 1;
            m_exc   = bad ? 4 : 0;
            m_instr = bad ? 0 : longint'(if_instr);
        end
    endtask

    task automatic cycle(input logic r, input logic f, input logic s,
                         input logic [31:0] pc, input logic [31:0] ins, input logic bd);
        reset = r; flush = f; stall = s; if_pc = pc; if_instr = ins; if_bd = bd;
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: rand_pc = 32'h0000_3000;
            1: rand_pc = 32'h0000_6FFC;
            2: rand_pc = 32'h0000_2FFC;
            3: rand_pc = 32'h0000_7000;
            4: rand_pc = $urandom;
            5: rand_pc = 32'h0000_3000 + 32'($urandom_range(0, 'h4000));
            default: rand_pc = 32'h0000_3000 + 32'($urandom_range(0, 'hFFF) * 4);
        endcase
    endfunction

    initial begin
        //            rst f  s  if_pc          if_instr       bd  id_pc          id_pc8         id_instr       exc  bd v  cnt
        vecs[0]  = '{1'b0,1'b0,1'b0,32'h00003000,32'hDEADBEEF,1'b0,32'h00003000,32'h00003008,32'h00000000,5'd0,1'b0,1'b0,16'd0};
        vecs[1]  = '{1'b0,1'b0,1'b0,32'h00003000,32'hDEADBEEF,1'b0,32'h00003000,32'h00003008,32'h00000000,5'd0,1'b0,1'b0,16'd0};
        vecs[2]  = '{1'b1,1'b0,1'b0,32'h00003000,32'h24010001,1'b0,32'h00003000,32'h00003008,32'h24010001,5'd0,1'b0,1'b1,16'd0};
        vecs[3]  = '{1'b1,1'b0,1'b0,32'h00003004,32'h11111111,1'b0,32'h00003004,32'h0000300C,32'h11111111,5'd0,1'b0,1'b1,16'd0};
        vecs[4]  = '{1'b1,1'b0,1'b1,32'h00003008,32'h22222222,1'b1,32'h00003004,32'h0000300C,32'h11111111,5'd0,1'b0,1'b1,16'd1};
        vecs[5]  = '{1'b1,1'b0,1'b1,32'h0000300C,32'h22222223,1'b0,32'h00003004,32'h0000300C,32'h11111111,5'd0,1'b0,1'b1,16'd2};
        vecs[6]  = '{1'b1,1'b0,1'b1,32'h00005000,32'h22222224,1'b1,32'h00003004,32'h0000300C,32'h11111111,5'd0,1'b0,1'b1,16'd3};
        vecs[7]  = '{1'b1,1'b0,1'b0,32'h00003002,32'h33333333,1'b0,32'h00003002,32'h0000300A,32'h00000000,5'd4,1'b0,1'b1,16'd3};
        vecs[8]  = '{1'b1,1'b0,1'b0,32'h00007000,32'h44444444,1'b0,32'h00007000,32'h00007008,32'h00000000,5'd4,1'b0,1'b1,16'd3};
        vecs[9]  = '{1'b1,1'b0,1'b0,32'h00006FFC,32'h55555555,1'b0,32'h00006FFC,32'h00007004,32'h55555555,5'd0,1'b0,1'b1,16'd3};
        vecs[10] = '{1'b1,1'b0,1'b0,32'h00002FFC,32'h66666666,1'b0,32'h00002FFC,32'h00003004,32'h00000000,5'd4,1'b0,1'b1,16'd3};
        vecs[11] = '{1'b1,1'b1,1'b1,32'h00003010,32'h12345678,1'b1,32'h00004180,32'h00004188,32'h00000000,5'd0,1'b0,1'b0,16'd3};
        vecs[12] = '{1'b1,1'b0,1'b1,32'h00003020,32'h87654321,1'b1,32'h00004180,32'h00004188,32'h00000000,5'd0,1'b0,1'b0,16'd4};
        vecs[13] = '{1'b1,1'b0,1'b0,32'h00003010,32'h77777777,1'b1,32'h00003010,32'h00003018,32'h77777777,5'd0,1'b1,1'b1,16'd4};
        vecs[14] = '{1'b1,1'b1,1'b0,32'h00003014,32'hAAAAAAAA,1'b1,32'h00004180,32'h00004188,32'h00000000,5'd0,1'b0,1'b0,16'd4};
        vecs[15] = '{1'b1,1'b0,1'b0,32'h00003000,32'h88888888,1'b0,32'h00003000,32'h00003008,32'h88888888,5'd0,1'b0,1'b1,16'd4};
        vecs[16] = '{1'b1,1'b0,1'b1,32'h00003008,32'hBBBBBBBB,1'b1,32'h00003000,32'h00003008,32'h88888888,5'd0,1'b0,1'b1,16'd5};
        vecs[17] = '{1'b0,1'b1,1'b1,32'h00003008,32'hCCCCCCCC,1'b1,32'h00003000,32'h00003008,32'h00000000,5'd0,1'b0,1'b0,16'd0};
        vecs[18] = '{1'b1,1'b0,1'b0,32'h00004000,32'h99999999,1'b0,32'h00004000,32'h00004008,32'h99999999,5'd0,1'b0,1'b1,16'd0};

        m_pc = 'h3000; m_pc8 = 'h3008; m_instr = 0; m_exc = 0;
        m_bd = 0; m_valid = 0; m_cnt = 0;
        reset = 1'b1; flush = 1'b0; stall = 1'b0;
        if_pc = 32'h3000; if_instr = 32'd0; if_bd = 1'b0;
        #1;
        chk_all("power_on", 32'h3000, 32'h3008, 32'd0, 5'd0, 1'b0, 1'b0, 16'd0);

        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].rst_n, vecs[i].fl, vecs[i].st, vecs[i].pc, vecs[i].instr, vecs[i].bd);
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_pc8, vecs[i].e_instr,
                    vecs[i].e_exc, vecs[i].e_bd, vecs[i].e_valid, vecs[i].e_cnt);
        end

        // Saturation run: clear, 65534 stalls, then three more.
        cycle(1'b0, 1'b0, 1'b0, 32'h3000, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h3100, 32'h0BADF00D, 1'b0);
        for (int i = 0; i < 65534; i++) begin
            cycle(1'b1, 1'b0, 1'b1, $urandom, $urandom, 1'($urandom));
        end
        chk_all("sat_fffe", 32'h3100, 32'h3108, 32'h0BADF00D, 5'd0, 1'b0, 1'b1, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, $urandom, $urandom, 1'b0);
            chk({"sat_cnt", $sformatf("%0d", i)}, {16'd0, stall_cnt}, 32'h0000FFFF);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h3000, 32'd0, 1'b0);
        chk_all("sat_reset", 32'h3000, 32'h3008, 32'd0, 5'd0, 1'b0, 1'b0, 16'd0);

        // Randomized traffic against the behavioural model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 29) != 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0), rand_pc(), $urandom, 1'($urandom));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
